// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one NEURON across NUM_NEURONS logical neurons: feeds each neuron the held input vector serially.
// Completes 1+NUM_NEURONS*(NUM_INPUTS+L+1) cycles after accept with NEU_READY high; NEU_VALID_IN/value hold while NEU_READY is low.
module neuron_layer_sequencer #(
   parameter int NUM_INPUTS  = 2,
   parameter int NUM_NEURONS = 4,
   parameter int WIDTH       = 8
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic [NUM_NEURONS*NUM_INPUTS*WIDTH-1:0] WEIGHTS,
   input  logic [NUM_NEURONS*WIDTH-1:0]          BIASES,
   input  logic [NUM_INPUTS*WIDTH-1:0]           LAYER_IN,
   input  logic                                  LAYER_VALID_IN,
   output logic                                  LAYER_READY,
   output logic [NUM_NEURONS*WIDTH-1:0]          LAYER_OUT,
   output logic                                  LAYER_VALID_OUT,
   output logic                                  LAYER_OVERFLOW,
   output logic [NUM_INPUTS*WIDTH-1:0]           NEU_WEIGHTS,
   output logic [WIDTH-1:0]                      NEU_BIAS,
   output logic [WIDTH-1:0]                      NEU_VALUE_IN,
   output logic                                  NEU_VALID_IN,
   input  logic                                  NEU_READY,
   input  logic [WIDTH-1:0]                      NEU_VALUE_OUT,
   input  logic                                  NEU_VALID_OUT,
   input  logic                                  NEU_OVERFLOW
);
   localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(NUM_INPUTS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_STORE, S_DONE} state_t;

   state_t                         r_state;
   logic [NW-1:0]                  r_n;
   logic [IW-1:0]                  r_i;
   logic [NUM_INPUTS*WIDTH-1:0]    r_in;
   logic [NUM_NEURONS*WIDTH-1:0]   r_out;
   logic                           r_acc;
   logic [NUM_NEURONS*WIDTH-1:0]   r_layer_out;
   logic                           r_layer_ovf;
   logic                           r_layer_vld;
   logic                           r_ready;
   logic                           r_neu_vld;
   logic                           w_busy;

   assign w_busy          = (r_state != S_IDLE);
   assign LAYER_READY     = r_ready;
   assign LAYER_OUT       = r_layer_out;
   assign LAYER_VALID_OUT = r_layer_vld;
   assign LAYER_OVERFLOW  = r_layer_ovf;
   assign NEU_VALID_IN    = r_neu_vld;
   // Slices follow the neuron counter live; the layer parameters are not snapshotted.
   assign NEU_WEIGHTS  = w_busy ? WEIGHTS[int'(r_n)*NUM_INPUTS*WIDTH +: NUM_INPUTS*WIDTH] : '0;
   assign NEU_BIAS     = w_busy ? BIASES[int'(r_n)*WIDTH +: WIDTH] : '0;
   assign NEU_VALUE_IN = r_neu_vld ? r_in[int'(r_i)*WIDTH +: WIDTH] : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_i         <= '0;
         r_in        <= '0;
         r_out       <= '0;
         r_acc       <= 1'b0;
         r_layer_out <= '0;
         r_layer_ovf <= 1'b0;
         r_layer_vld <= 1'b0;
         r_ready     <= 1'b1;
         r_neu_vld   <= 1'b0;
      end else begin
         r_layer_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (LAYER_VALID_IN) begin
                  r_in      <= LAYER_IN;
                  r_n       <= '0;
                  r_i       <= '0;
                  r_acc     <= 1'b0;
                  r_ready   <= 1'b0;
                  r_neu_vld <= 1'b1;
                  r_state   <= S_FEED;
               end
            end
            S_FEED: begin
               r_acc <= r_acc | NEU_OVERFLOW;
               if (NEU_READY) begin
                  if (r_i == I_LAST) begin
                     r_neu_vld <= 1'b0;
                     r_state   <= S_WAIT;
                  end else begin
                     r_i <= r_i + IW'(1);
                  end
               end
            end
            S_WAIT: begin
               r_acc <= r_acc | NEU_OVERFLOW;
               if (NEU_VALID_OUT) begin
                  r_out[int'(r_n)*WIDTH +: WIDTH] <= NEU_VALUE_OUT;
                  r_state <= S_STORE;
               end
            end
            S_STORE: begin
               // The neuron's overflow lags its result by one cycle, so it is folded in here.
               r_acc <= r_acc | NEU_OVERFLOW;
               if (r_n == N_LAST) begin
                  r_layer_out <= r_out;
                  r_layer_ovf <= r_acc | NEU_OVERFLOW;
                  r_layer_vld <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_n       <= r_n + NW'(1);
                  r_i       <= '0;
                  r_neu_vld <= 1'b1;
                  r_state   <= S_FEED;
               end
            end
            S_DONE: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready   <= 1'b1;
               r_neu_vld <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end
endmodule
